// File: rtl/product_accumulator.sv
// Sums LEN consecutive unsigned products into one ACCW-bit result behind a 1-entry valid/ready output register.
// Optional build macro SATURATE_EN: clamp the vector sum at all-ones on overflow instead of wrapping.
module product_accumulator #(
    parameter int WIDTH = 4,
    parameter int LEN   = 4,
    parameter int ACCW  = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*WIDTH-1:0]   prod,
    input  logic                 prod_valid,
    output logic                 prod_ready,
    input  logic                 clear,
    output logic [ACCW-1:0]      acc_out,
    output logic                 acc_ovf,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    typedef enum logic {ACC_IDLE = 1'b0, ACC_RUN = 1'b1} acc_state_t;
    typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

    acc_state_t        acc_state_q, acc_state_d;
    out_state_t        out_state_q, out_state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [ACCW-1:0]   acc_out_q, acc_out_d;
    logic              acc_ovf_q, acc_ovf_d;

    logic [ACCW:0]     prod_ext_s;
    logic [ACCW:0]     sum_s;
    logic              carry_s;
    logic [ACCW-1:0]   next_acc_s;
    logic              last_s;
    logic              accept_s;
    logic              complete_s;
    logic              prod_ready_s;

    // Datapath: zero-extended add with carry capture, wrap or clamp
    always_comb begin
        prod_ext_s = {{(ACCW + 1 - PW){1'b0}}, prod};
        sum_s      = {1'b0, acc_q} + prod_ext_s;
        carry_s    = sum_s[ACCW];
`ifdef SATURATE_EN
        // Once clamped, the sum stays clamped until the vector ends
        if (carry_s || ovf_q) begin
            next_acc_s = {ACCW{1'b1}};
        end else begin
            next_acc_s = sum_s[ACCW-1:0];
        end
`else
        next_acc_s = sum_s[ACCW-1:0];
`endif
    end

    // Handshake qualifiers; only a full, stalled output can block the closing product
    always_comb begin
        last_s       = (cnt_q == CNT_LAST);
        prod_ready_s = !((out_state_q == OUT_FULL) && !acc_ready && last_s) && rst_n;
        accept_s     = prod_valid && prod_ready_s;
        complete_s   = accept_s && last_s && !clear;
    end

    // Accumulator FSM next-state: clear wins over an accepted product
    always_comb begin
        acc_state_d = acc_state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        if (clear) begin
            acc_state_d = ACC_IDLE;
            cnt_d       = {CW{1'b0}};
            acc_d       = {ACCW{1'b0}};
            ovf_d       = 1'b0;
        end else if (accept_s) begin
            if (last_s) begin
                acc_state_d = ACC_IDLE;
                cnt_d       = {CW{1'b0}};
                acc_d       = {ACCW{1'b0}};
                ovf_d       = 1'b0;
            end else begin
                acc_state_d = ACC_RUN;
                cnt_d       = cnt_q + CW'(1);
                acc_d       = next_acc_s;
                ovf_d       = ovf_q | carry_s;
            end
        end else begin
            acc_state_d = acc_state_q;
        end
    end

    // Output register FSM next-state: reload on completion, drain on acc_ready
    always_comb begin
        out_state_d = out_state_q;
        acc_out_d   = acc_out_q;
        acc_ovf_d   = acc_ovf_q;
        case (out_state_q)
            OUT_EMPTY: begin
                if (complete_s) begin
                    out_state_d = OUT_FULL;
                    acc_out_d   = next_acc_s;
                    acc_ovf_d   = ovf_q | carry_s;
                end else begin
                    out_state_d = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (complete_s) begin
                    out_state_d = OUT_FULL;
                    acc_out_d   = next_acc_s;
                    acc_ovf_d   = ovf_q | carry_s;
                end else if (acc_ready) begin
                    out_state_d = OUT_EMPTY;
                end else begin
                    out_state_d = OUT_FULL;
                end
            end
            default: begin
                out_state_d = OUT_EMPTY;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_state_q <= ACC_IDLE;
            out_state_q <= OUT_EMPTY;
            cnt_q       <= {CW{1'b0}};
            acc_q       <= {ACCW{1'b0}};
            ovf_q       <= 1'b0;
            acc_out_q   <= {ACCW{1'b0}};
            acc_ovf_q   <= 1'b0;
        end else begin
            acc_state_q <= acc_state_d;
            out_state_q <= out_state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            acc_out_q   <= acc_out_d;
            acc_ovf_q   <= acc_ovf_d;
        end
    end

    assign prod_ready = prod_ready_s;
    assign acc_out    = acc_out_q;
    assign acc_ovf    = acc_ovf_q;
    assign acc_valid  = (out_state_q == OUT_FULL);
    assign busy       = (acc_state_q == ACC_RUN);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: per-cycle vector table plus hand sequences for wrap/clamp and async reset.
module tb_product_accumulator;

`ifdef SATURATE_EN
    localparam logic [8:0] EXP9 = 9'd511;
`else
    localparam logic [8:0] EXP9 = 9'd388;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  prod;
    logic        prod_valid, prod_ready, clear, acc_ovf, acc_valid, acc_ready, busy;
    logic [11:0] acc_out;

    logic [7:0]  prod9;
    logic        pv9, pr9, clr9, ovf9, val9, ar9, busy9;
    logic [8:0]  out9;

    int n_vec = 0;
    int n_err = 0;

    product_accumulator #(.WIDTH(4), .LEN(4), .ACCW(12)) dut (
        .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .clear(clear), .acc_out(acc_out), .acc_ovf(acc_ovf), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .busy(busy)
    );

    product_accumulator #(.WIDTH(4), .LEN(4), .ACCW(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .prod(prod9), .prod_valid(pv9), .prod_ready(pr9),
        .clear(clr9), .acc_out(out9), .acc_ovf(ovf9), .acc_valid(val9),
        .acc_ready(ar9), .busy(busy9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [7:0]  p;
        logic        clr;
        logic        ar;
        logic        e_pr;
        logic        e_v;
        logic [11:0] e_out;
        logic        e_ovf;
        logic        e_busy;
    } vec_t;

    vec_t tbl [30];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        prod_valid = v.pv;
        prod       = v.p;
        clear      = v.clr;
        acc_ready  = v.ar;
        #1;
        chk($sformatf("v%0d_prod_ready", idx), {31'd0, prod_ready}, {31'd0, v.e_pr});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_acc_valid", idx), {31'd0, acc_valid}, {31'd0, v.e_v});
        chk($sformatf("v%0d_acc_out", idx), {20'd0, acc_out}, {20'd0, v.e_out});
        chk($sformatf("v%0d_acc_ovf", idx), {31'd0, acc_ovf}, {31'd0, v.e_ovf});
        chk($sformatf("v%0d_busy", idx), {31'd0, busy}, {31'd0, v.e_busy});
    endtask

    initial begin
        //           pv    p        clr   ar    e_pr  e_v   e_out     ovf   busy
        // 225 x4 back-to-back: 900 appears right after the 4th accept
        tbl[0]  = '{1'b1, 8'd225, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,   1'b0, 1'b1};
        tbl[1]  = '{1'b1, 8'd225, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,   1'b0, 1'b1};
        tbl[2]  = '{1'b1, 8'd225, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,   1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8'd225, 1'b0, 1'b1, 1'b1, 1'b1, 12'd900, 1'b0, 1'b0};
        // 1..4 then 5..8 continuous with acc_ready=1
        tbl[4]  = '{1'b1, 8'd1,   1'b0, 1'b1, 1'b1, 1'b0, 12'd900, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 8'd2,   1'b0, 1'b1, 1'b1, 1'b0, 12'd900, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'd3,   1'b0, 1'b1, 1'b1, 1'b0, 12'd900, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 8'd4,   1'b0, 1'b1, 1'b1, 1'b1, 12'd10,  1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'd5,   1'b0, 1'b1, 1'b1, 1'b0, 12'd10,  1'b0, 1'b1};
        tbl[9]  = '{1'b1, 8'd6,   1'b0, 1'b1, 1'b1, 1'b0, 12'd10,  1'b0, 1'b1};
        tbl[10] = '{1'b1, 8'd7,   1'b0, 1'b1, 1'b1, 1'b0, 12'd10,  1'b0, 1'b1};
        tbl[11] = '{1'b1, 8'd8,   1'b0, 1'b1, 1'b1, 1'b1, 12'd26,  1'b0, 1'b0};
        // backpressure: result 10 stalls, 4th product of the next vector blocked
        tbl[12] = '{1'b1, 8'd1,   1'b0, 1'b1, 1'b1, 1'b0, 12'd26,  1'b0, 1'b1};
        tbl[13] = '{1'b1, 8'd2,   1'b0, 1'b1, 1'b1, 1'b0, 12'd26,  1'b0, 1'b1};
        tbl[14] = '{1'b1, 8'd3,   1'b0, 1'b1, 1'b1, 1'b0, 12'd26,  1'b0, 1'b1};
        tbl[15] = '{1'b1, 8'd4,   1'b0, 1'b0, 1'b1, 1'b1, 12'd10,  1'b0, 1'b0};
        tbl[16] = '{1'b1, 8'd5,   1'b0, 1'b0, 1'b1, 1'b1, 12'd10,  1'b0, 1'b1};
        tbl[17] = '{1'b1, 8'd6,   1'b0, 1'b0, 1'b1, 1'b1, 12'd10,  1'b0, 1'b1};
        tbl[18] = '{1'b1, 8'd7,   1'b0, 1'b0, 1'b1, 1'b1, 12'd10,  1'b0, 1'b1};
        tbl[19] = '{1'b1, 8'd8,   1'b0, 1'b0, 1'b0, 1'b1, 12'd10,  1'b0, 1'b1};
        tbl[20] = '{1'b1, 8'd8,   1'b0, 1'b1, 1'b1, 1'b1, 12'd26,  1'b0, 1'b0};
        tbl[21] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b1, 1'b0, 12'd26,  1'b0, 1'b0};
        // clear mid-vector drops the product presented with it
        tbl[22] = '{1'b1, 8'd9,   1'b0, 1'b1, 1'b1, 1'b0, 12'd26,  1'b0, 1'b1};
        tbl[23] = '{1'b1, 8'd9,   1'b0, 1'b1, 1'b1, 1'b0, 12'd26,  1'b0, 1'b1};
        tbl[24] = '{1'b1, 8'd9,   1'b1, 1'b1, 1'b1, 1'b0, 12'd26,  1'b0, 1'b0};
        tbl[25] = '{1'b1, 8'd1,   1'b0, 1'b1, 1'b1, 1'b0, 12'd26,  1'b0, 1'b1};
        tbl[26] = '{1'b1, 8'd1,   1'b0, 1'b1, 1'b1, 1'b0, 12'd26,  1'b0, 1'b1};
        tbl[27] = '{1'b1, 8'd1,   1'b0, 1'b1, 1'b1, 1'b0, 12'd26,  1'b0, 1'b1};
        tbl[28] = '{1'b1, 8'd1,   1'b0, 1'b0, 1'b1, 1'b1, 12'd4,   1'b0, 1'b0};
        // clear with no product leaves the held result alone
        tbl[29] = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b1, 12'd4,   1'b0, 1'b0};

        rst_n = 1'b0; prod = 8'd0; prod_valid = 1'b0; clear = 1'b0; acc_ready = 1'b0;
        prod9 = 8'd0; pv9 = 1'b0; clr9 = 1'b0; ar9 = 1'b1;
        #2;
        chk("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
        chk("rst_acc_out", {20'd0, acc_out}, 32'd0);
        chk("rst_acc_ovf", {31'd0, acc_ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_prod_ready", {31'd0, prod_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            apply(tbl[i], i);
        end

        // ACCW=9: 225 x4 overflows on the 3rd product
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pv9 = 1'b1; prod9 = 8'd225;
            @(posedge clk);
            #1;
            chk($sformatf("ovf9_valid_%0d", k), {31'd0, val9}, (k == 3) ? 32'd1 : 32'd0);
        end
        chk("ovf9_out", {23'd0, out9}, {23'd0, EXP9});
        chk("ovf9_flag", {31'd0, ovf9}, 32'd1);
        // overflow flag must not leak into the next vector
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pv9 = 1'b1; prod9 = 8'd1;
            @(posedge clk);
        end
        #1;
        chk("ovf9_next_out", {23'd0, out9}, 32'd4);
        chk("ovf9_next_flag", {31'd0, ovf9}, 32'd0);
        @(negedge clk);
        pv9 = 1'b0;

        // async reset mid-vector while a result is held
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            prod_valid = 1'b1; prod = 8'd2; clear = 1'b0; acc_ready = 1'b0;
            @(posedge clk);
        end
        #1;
        chk("pre_rst_valid", {31'd0, acc_valid}, 32'd1);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        prod_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, acc_valid}, 32'd0);
        chk("arst_out", {20'd0, acc_out}, 32'd0);
        chk("arst_ovf", {31'd0, acc_ovf}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_prod_ready", {31'd0, prod_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            prod_valid = 1'b1; prod = 8'd2; acc_ready = 1'b1;
            @(posedge clk);
        end
        #1;
        chk("post_rst_valid", {31'd0, acc_valid}, 32'd1);
        chk("post_rst_out", {20'd0, acc_out}, 32'd8);
        @(negedge clk);
        prod_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
